// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared types and constants for the gate truth-table sequencer
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int VEC_COUNT = 4;
  localparam int IDX_W     = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - saturating hold counter; expired flags the last cycle of a hold window
module hold_timer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_CYCLES);

  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("hold_timer: HOLD_CYCLES must be >= 1");
    end
    if ((HOLD_CYCLES >> CNT_W) != 0) begin : g_bad_width
      $error("hold_timer: CNT_W too narrow for HOLD_CYCLES");
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_inc;

  // One extra bit so the increment cannot wrap when HOLD_CYCLES sits at the top of the range.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign expired   = en && (w_cnt_inc >= {1'b0, LIMIT});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != LIMIT)) begin
      r_cnt <= w_cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/gate_truth_sequencer.sv
// rtl/gate_truth_sequencer.sv - drives all {x,y} vectors into a 2-input gate, builds and checks its truth table
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [VEC_COUNT-1:0] exp_tt,
  output logic                 x,
  output logic                 y,
  input  logic                 z,
  output logic                 busy,
  output logic                 done,
  output logic [VEC_COUNT-1:0] truth_tt,
  output logic                 match
);

  state_t               r_state;
  state_t               w_next;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic [VEC_COUNT-1:0] r_exp;
  logic [VEC_COUNT-1:0] r_truth;
  logic [VEC_COUNT-1:0] w_sampled_tt;
  logic                 r_x;
  logic                 r_y;
  logic                 r_match;
  logic                 w_accept;
  logic                 w_expired;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (r_state != DRIVE),
    .en      (r_state == DRIVE),
    .expired (w_expired)
  );

  assign w_accept   = (r_state == IDLE) && start && !abort;
  assign w_idx_next = r_idx + IDX_W'(1);

  always_comb begin
    w_sampled_tt        = r_truth;
    w_sampled_tt[r_idx] = z;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = DRIVE;
      DRIVE:   if (abort) w_next = IDLE;
               else if (w_expired) w_next = SAMPLE;
      SAMPLE:  if (abort) w_next = IDLE;
               else if (r_idx == LAST_IDX) w_next = DONE;
               else w_next = DRIVE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // match is resolved on the final SAMPLE edge so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_exp   <= '0;
      r_truth <= '0;
      r_x     <= 1'b0;
      r_y     <= 1'b0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx   <= '0;
            r_truth <= '0;
            r_match <= 1'b0;
            r_exp   <= exp_tt;
            r_x     <= 1'b0;
            r_y     <= 1'b0;
          end
        end
        DRIVE: begin
          if (abort) begin
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_match <= 1'b0;
          end
        end
        SAMPLE: begin
          if (abort) begin
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_match <= 1'b0;
          end else begin
            r_truth <= w_sampled_tt;
            if (r_idx == LAST_IDX) begin
              r_match <= (w_sampled_tt == r_exp);
            end else begin
              r_idx      <= w_idx_next;
              {r_x, r_y} <= w_idx_next;
            end
          end
        end
        DONE: begin
          r_x <= 1'b0;
          r_y <= 1'b0;
          if (abort) r_match <= 1'b0;
        end
        default: begin
          r_x <= 1'b0;
          r_y <= 1'b0;
        end
      endcase
    end
  end

  assign x        = r_x;
  assign y        = r_y;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE) && !abort;
  assign truth_tt = r_truth;
  assign match    = r_match;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb/tb_gate_truth_sequencer.sv - bench for gate_truth_sequencer with HOLD_CYCLES=4 and HOLD_CYCLES=1 instances
module tb_gate_truth_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, abort4 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic [3:0] exp4 = 4'd0, exp1 = 4'd0;
  logic       x4, y4, z4, busy4, done4, match4;
  logic       x1, y1, z1, busy1, done1, match1;
  logic [3:0] tt4, tt1;
  int         g4 = 0, g1 = 2;
  int         n_pass = 0, n_total = 0;

  int         m_h[2] = '{4, 1};
  int         m_k[2] = '{0, 0};
  logic [3:0] m_tt[2] = '{4'd0, 4'd0};
  logic [3:0] m_exp[2] = '{4'd0, 4'd0};
  logic       m_match[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  // gate kinds: 0 = AND, 1 = XOR, otherwise OR
  function automatic logic gate_f(int g, logic a, logic b);
    case (g)
      0:       return a & b;
      1:       return a ^ b;
      default: return a | b;
    endcase
  endfunction

  assign z4 = gate_f(g4, x4, y4);
  assign z1 = gate_f(g1, x1, y1);

  gate_truth_sequencer #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .exp_tt(exp4),
    .x(x4), .y(y4), .z(z4), .busy(busy4), .done(done4), .truth_tt(tt4), .match(match4)
  );

  gate_truth_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .exp_tt(exp1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .truth_tt(tt1), .match(match1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Model: m_k counts cycles since the accepting edge; each vector takes H+1 cycles, done is cycle 4*(H+1)+1.
  task automatic step(input int i, input logic st, input logic ab, input logic [3:0] e, input int g);
    int per;
    int v;
    per = m_h[i] + 1;
    if (m_k[i] == 0) begin
      if (st && !ab) begin
        m_k[i] = 1; m_exp[i] = e; m_tt[i] = 4'd0; m_match[i] = 1'b0;
      end
    end else if (ab) begin
      m_k[i] = 0; m_match[i] = 1'b0;
    end else if (m_k[i] == 4 * per + 1) begin
      m_k[i] = 0;
    end else begin
      if (m_k[i] % per == 0) begin
        v = m_k[i] / per - 1;
        m_tt[i][v] = gate_f(g, v[1], v[0]);
        if (v == 3) m_match[i] = (m_tt[i] == m_exp[i]);
      end
      m_k[i]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_k[i] = 0; m_tt[i] = 4'd0; m_exp[i] = 4'd0; m_match[i] = 1'b0;
      end
    end else begin
      step(0, start4, abort4, exp4, g4);
      step(1, start1, abort1, exp1, g1);
    end
  end

  task automatic cmp(input int i, input logic xa, input logic ya, input logic ba, input logic da,
                     input logic [3:0] ta, input logic ma, input logic ab);
    int   per;
    int   k;
    int   v;
    logic ex, ey, eb, ed;
    per = m_h[i] + 1;
    k = m_k[i];
    v = 0;
    if (k == 0) begin
      ex = 1'b0; ey = 1'b0; eb = 1'b0; ed = 1'b0;
    end else if (k <= 4 * per) begin
      v = (k - 1) / per;
      ex = v[1]; ey = v[0]; eb = 1'b1; ed = 1'b0;
    end else begin
      ex = 1'b1; ey = 1'b1; eb = 1'b1; ed = !ab;
    end
    check($sformatf("h%0d.x@k%0d", m_h[i], k), xa, ex);
    check($sformatf("h%0d.y@k%0d", m_h[i], k), ya, ey);
    check($sformatf("h%0d.busy@k%0d", m_h[i], k), ba, eb);
    check($sformatf("h%0d.done@k%0d", m_h[i], k), da, ed);
    check($sformatf("h%0d.truth_tt@k%0d", m_h[i], k), ta, m_tt[i]);
    check($sformatf("h%0d.match@k%0d", m_h[i], k), ma, m_match[i]);
  endtask

  always @(negedge clk) begin
    cmp(0, x4, y4, busy4, done4, tt4, match4, abort4);
    cmp(1, x1, y1, busy1, done1, tt1, match1, abort1);
  end

  task automatic go4(input logic [3:0] e, input int g);
    @(posedge clk); #2;
    g4 = g; exp4 = e; start4 = 1'b1;
    @(posedge clk); #2;
    start4 = 1'b0;
  endtask

  task automatic run4(input int max, input int rep_a, input int rep_b, input int abort_at,
                      output int done_at, output int pulses);
    done_at = -1;
    pulses  = 0;
    for (int c = 1; c <= max; c++) begin
      @(negedge clk);
      if (done4) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
      #1;
      start4 = (c == rep_a) || (c == rep_b);
      abort4 = (c == abort_at);
    end
    start4 = 1'b0;
    abort4 = 1'b0;
  endtask

  initial begin
    int         d;
    int         p;
    logic [1:0] xy_seen[8];
    logic [1:0] xy_req[8];

    xy_req = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};

    @(negedge clk);
    check("reset.busy", busy4, 1'b0);
    check("reset.done", done4, 1'b0);
    check("reset.xy", {x4, y4}, 2'b00);
    check("reset.truth_tt", tt4, 4'b0000);
    check("reset.match", match4, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 1: AND, expected table matches
    go4(4'b1000, 0);
    run4(30, 0, 0, 0, d, p);
    check("and.done_cycle", d, 21);
    check("and.done_pulses", p, 1);
    check("and.truth_tt", tt4, 4'b1000);
    check("and.match", match4, 1'b1);

    // 2: XOR against AND table
    go4(4'b1000, 1);
    run4(30, 0, 0, 0, d, p);
    check("xor.done_cycle", d, 21);
    check("xor.done_pulses", p, 1);
    check("xor.truth_tt", tt4, 4'b0110);
    check("xor.match", match4, 1'b0);

    // 3: abort during vector idx=2 DRIVE
    go4(4'b1000, 0);
    run4(40, 0, 0, 12, d, p);
    check("abort.done_pulses", p, 0);
    check("abort.busy", busy4, 1'b0);
    check("abort.xy", {x4, y4}, 2'b00);
    check("abort.truth_tt", tt4, 4'b0000);
    check("abort.match", match4, 1'b0);

    // start together with abort in IDLE is refused
    @(posedge clk); #2;
    start4 = 1'b1; abort4 = 1'b1;
    @(posedge clk); #2;
    start4 = 1'b0; abort4 = 1'b0;
    @(negedge clk);
    check("start_abort.busy", busy4, 1'b0);

    // 4: start re-pulsed during the scan is ignored
    go4(4'b1000, 0);
    run4(30, 5, 10, 0, d, p);
    check("repulse.done_cycle", d, 21);
    check("repulse.done_pulses", p, 1);
    check("repulse.idle_after", busy4, 1'b0);
    go4(4'b0110, 1);
    run4(30, 0, 0, 0, d, p);
    check("rescan.done_cycle", d, 21);
    check("rescan.truth_tt", tt4, 4'b0110);
    check("rescan.match", match4, 1'b1);

    // 5: reset mid-scan clears outputs immediately
    go4(4'b1000, 0);
    repeat (8) @(negedge clk);
    check("prereset.busy", busy4, 1'b1);
    check("prereset.xy", {x4, y4}, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    check("midreset.busy", busy4, 1'b0);
    check("midreset.xy", {x4, y4}, 2'b00);
    check("midreset.done", done4, 1'b0);
    check("midreset.truth_tt", tt4, 4'b0000);
    @(posedge clk); #2;
    rst_n = 1'b1;
    go4(4'b1000, 0);
    run4(30, 0, 0, 0, d, p);
    check("postreset.done_cycle", d, 21);
    check("postreset.truth_tt", tt4, 4'b1000);
    check("postreset.match", match4, 1'b1);

    // 6: HOLD_CYCLES=1, OR gate
    @(posedge clk); #2;
    g1 = 2; exp1 = 4'b1110; start1 = 1'b1;
    @(posedge clk); #2;
    start1 = 1'b0;
    d = -1;
    p = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c <= 8) xy_seen[c-1] = {x1, y1};
      if (done1) begin
        p++;
        if (d < 0) d = c;
      end
    end
    check("h1.done_cycle", d, 9);
    check("h1.done_pulses", p, 1);
    check("h1.truth_tt", tt1, 4'b1110);
    check("h1.match", match1, 1'b1);
    for (int c = 0; c < 8; c++) check($sformatf("h1.xy_cycle%0d", c + 1), xy_seen[c], xy_req[c]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
